dsp_seq_divider: RTL and testbench

Iterative unsigned restoring divider. It is the inverse companion to the team's multiply-accumulate DSP pipeline: it takes a wide 48-bit accumulator-style result as the dividend and an 18-bit operand as the divisor, and recovers the quotient and remainder. It produces one quotient bit per clock. Operands enter and results leave through valid/ready handshakes, so the block sits directly downstream of the DSP datapath.

---
 rtl/dsp_div_pkg.sv | 28 ++
 rtl/dsp_div_step.sv | 42 ++++
 rtl/dsp_seq_divider.sv | 164 ++++++++++++++++
 tb/tb_dsp_seq_divider.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_div_pkg.sv
// -----------------------------------------------------------------------------
// dsp_div_pkg
// Shared definitions for the sequential restoring divider:
//   - default operand widths (DSP P width for the dividend, A/B/D width for
//     the divisor)
//   - FSM state encoding
//   - bit-counter width helper
// No ports (package).
// -----------------------------------------------------------------------------
package dsp_div_pkg;

    localparam int DEF_DIVIDEND_W = 48;
    localparam int DEF_DIVISOR_W  = 18;

    // Counter must be able to count every quotient bit of the dividend.
    function automatic int cnt_width(input int dividend_w);
        return $clog2(dividend_w + 1);
    endfunction

    localparam int DEF_CNT_W = cnt_width(DEF_DIVIDEND_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/dsp_div_step.sv
// -----------------------------------------------------------------------------
// dsp_div_step
// One combinational restoring-division step: shift the next dividend bit into
// the partial remainder, trial-subtract the divisor, keep the difference when
// it does not go negative.
//
// Ports:
//   i_pr       partial remainder entering the step (always < divisor)
//   i_bit      next dividend bit, MSB first
//   i_divisor  divisor (non-zero while stepping)
//   o_pr       partial remainder leaving the step (always < divisor)
//   o_qbit     quotient bit produced by this step
// -----------------------------------------------------------------------------
module dsp_div_step
    import dsp_div_pkg::*;
#(
    parameter int DIVISOR_W = DEF_DIVISOR_W
) (
    input  logic [DIVISOR_W-1:0] i_pr,
    input  logic                 i_bit,
    input  logic [DIVISOR_W-1:0] i_divisor,
    output logic [DIVISOR_W-1:0] o_pr,
    output logic                 o_qbit
);

    logic [DIVISOR_W:0]   w_shifted;
    logic [DIVISOR_W-1:0] w_diff;
    logic                 w_ge;

    // The shifted remainder needs one extra bit: 2*(divisor-1)+1 can exceed
    // the divisor width, so the compare is done DIVISOR_W+1 bits wide.
    assign w_shifted = {i_pr, i_bit};
    assign w_ge      = (w_shifted >= {1'b0, i_divisor});

    // When w_ge is set the true difference is below the divisor, so the
    // low DIVISOR_W bits of the subtraction are exact.
    assign w_diff    = w_shifted[DIVISOR_W-1:0] - i_divisor;

    assign o_pr      = w_ge ? w_diff : w_shifted[DIVISOR_W-1:0];
    assign o_qbit    = w_ge;

endmodule

// File: rtl/dsp_seq_divider.sv
// -----------------------------------------------------------------------------
// dsp_seq_divider
// Iterative unsigned restoring divider, one quotient bit per clock. Takes a
// DSP accumulator-width dividend and an operand-width divisor and returns
// quotient and remainder.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   in_valid     dividend/divisor valid
//   in_ready     block can accept an operation (IDLE)
//   dividend     unsigned dividend, DIVIDEND_W bits
//   divisor      unsigned divisor, DIVISOR_W bits
//   out_valid    quotient/remainder/div_by_zero valid (DONE)
//   out_ready    downstream accepts the result
//   quotient     unsigned quotient, DIVIDEND_W bits
//   remainder    unsigned remainder, DIVISOR_W bits
//   div_by_zero  result came from a zero divisor
//   state_dbg    current FSM state (IDLE=0, CALC=1, DONE=2)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. in_ready depends only on state (never on in_valid); out_valid,
// once raised, stays high with stable result fields until the edge where
// out_ready is sampled high. Inputs are ignored whenever in_ready is low.
//
// Timing: a non-zero divisor finishes DIVIDEND_W edges after acceptance; a
// zero divisor finishes on the accepting edge. Accepting is only possible
// from IDLE, so the result cycle and the next acceptance never overlap.
// -----------------------------------------------------------------------------
module dsp_seq_divider
    import dsp_div_pkg::*;
#(
    parameter int DIVIDEND_W = DEF_DIVIDEND_W,
    parameter int DIVISOR_W  = DEF_DIVISOR_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero,
    output logic [1:0]            state_dbg
);

    localparam int                CNT_W     = cnt_width(DIVIDEND_W);
    localparam logic [CNT_W-1:0]  LAST_STEP = CNT_W'(DIVIDEND_W - 1);

    div_state_e            r_state;
    div_state_e            w_state_next;

    // r_shift starts as the dividend; each step shifts its MSB out into the
    // partial remainder and shifts the new quotient bit in at the LSB, so
    // after DIVIDEND_W steps it holds the quotient.
    logic [DIVIDEND_W-1:0] r_shift;
    // The partial remainder is always below the divisor between steps, so it
    // is stored DIVISOR_W wide; the step widens it by one bit internally.
    logic [DIVISOR_W-1:0]  r_pr;
    logic [DIVISOR_W-1:0]  r_divisor;
    logic [CNT_W-1:0]      r_cnt;
    logic [DIVIDEND_W-1:0] r_quotient;
    logic [DIVISOR_W-1:0]  r_remainder;
    logic                  r_dbz;

    logic                  w_qbit;
    logic [DIVISOR_W-1:0]  w_pr_next;
    logic [DIVIDEND_W-1:0] w_shift_next;
    logic                  w_last;
    logic                  w_accept;

    dsp_div_step #(
        .DIVISOR_W (DIVISOR_W)
    ) u_step (
        .i_pr      (r_pr),
        .i_bit     (r_shift[DIVIDEND_W-1]),
        .i_divisor (r_divisor),
        .o_pr      (w_pr_next),
        .o_qbit    (w_qbit)
    );

    assign w_shift_next = {r_shift[DIVIDEND_W-2:0], w_qbit};
    assign w_last       = (r_cnt == LAST_STEP);
    assign w_accept     = (r_state == IDLE) && in_valid;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_state_next = (divisor == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_shift     <= '0;
            r_pr        <= '0;
            r_divisor   <= '0;
            r_cnt       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
        end else begin
            if (w_accept) begin
                if (divisor != '0) begin
                    r_shift   <= dividend;
                    r_pr      <= '0;
                    r_divisor <= divisor;
                    r_cnt     <= '0;
                end else begin
                    // Zero divisor: saturated quotient, dividend low bits
                    // as remainder, flagged; no iteration needed.
                    r_quotient  <= '1;
                    r_remainder <= dividend[DIVISOR_W-1:0];
                    r_dbz       <= 1'b1;
                end
            end else if (r_state == CALC) begin
                r_shift <= w_shift_next;
                r_pr    <= w_pr_next;
                r_cnt   <= r_cnt + 1'b1;
                if (w_last) begin
                    r_quotient  <= w_shift_next;
                    r_remainder <= w_pr_next;
                    r_dbz       <= 1'b0;
                end
            end
        end
    end

    assign in_ready    = (r_state == IDLE);
    assign out_valid   = (r_state == DONE);
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_dbz;
    assign state_dbg   = r_state;

endmodule

// File: tb/tb_dsp_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_dsp_seq_divider
// Directed and random stimulus for dsp_seq_divider. Expected results are
// pushed when an operation is issued; a negedge monitor compares them when
// the DUT presents out_valid.
// -----------------------------------------------------------------------------
module tb_dsp_seq_divider;

    localparam int AW = 48;
    localparam int BW = 18;
    localparam int RW = 1 + AW + BW;      // {dbz, quotient, remainder}
    localparam int EW = 8 + RW;           // {latency, result}

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] dividend;
    logic [BW-1:0] divisor;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] quotient;
    logic [BW-1:0] remainder;
    logic          div_by_zero;
    logic [1:0]    state_dbg;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [EW-1:0] exp_q[$];
    int            acc_q[$];
    int            prev_acc = -1;
    int            prev_lat = 0;
    int            or_mode  = 0;    // 0: always ready, 1: random stalls, 2: hold low
    bit            seen_valid = 1'b0;
    bit            chk_after  = 1'b0;

    dsp_seq_divider dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .state_dbg   (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // out_ready is changed just after the rising edge so it is stable
    // for the whole following cycle.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (or_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b0;
            endcase
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // lat = edges after the accepting edge at which out_valid rises
    // (48 for a normal division, 0 for a zero divisor).
    task automatic issue(input logic [AW-1:0] a, input logic [BW-1:0] b,
                         input logic [AW-1:0] eq, input logic [BW-1:0] er,
                         input logic ed, input int lat);
        int guard;
        guard = 0;
        @(negedge clk);
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        while (!in_ready && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL issue_timeout: in_ready=0 after %0d cycles, required 1", guard);
            in_valid = 1'b0;
            return;
        end
        if (prev_acc >= 0) begin
            n_tests++;
            if (cyc - prev_acc < prev_lat + 2) begin
                n_fail++;
                $display("FAIL issue_interval: got %0d cycles, required >= %0d",
                         cyc - prev_acc, prev_lat + 2);
            end
        end
        prev_acc = cyc;
        prev_lat = lat;
        exp_q.push_back({lat[7:0], ed, eq, er});
        acc_q.push_back(cyc);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic issue_model(input logic [AW-1:0] a, input logic [BW-1:0] b);
        if (b == '0) issue(a, b, '1, a[BW-1:0], 1'b1, 0);
        else         issue(a, b, a / AW'(b), BW'(a % AW'(b)), 1'b0, 48);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
            exp_q.delete();
            acc_q.delete();
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic pulse_reset(input int n);
        @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        acc_q.delete();
        prev_acc   = -1;
        seen_valid = 1'b0;
        chk_after  = 1'b0;
        repeat (n) @(negedge clk);
        rst_n = 1'b1;
        check("rst_out_valid",   out_valid,   0);
        check("rst_in_ready",    in_ready,    1);
        check("rst_quotient",    quotient,    0);
        check("rst_remainder",   remainder,   0);
        check("rst_div_by_zero", div_by_zero, 0);
        check("rst_state",       state_dbg,   0);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [EW-1:0] e;
        int            lat_got;
        if (rst_n === 1'b1) begin
            if (chk_after) begin
                chk_after = 1'b0;
                n_tests++;
                if (!(in_ready === 1'b1 && out_valid === 1'b0)) begin
                    n_fail++;
                    $display("FAIL post_consume: in_ready=%0b out_valid=%0b required 1/0",
                             in_ready, out_valid);
                end
            end
            if (out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_output: q=%0h r=%0h dbz=%0b with nothing issued",
                             quotient, remainder, div_by_zero);
                end else begin
                    e = exp_q[0];
                    if (!seen_valid) begin
                        seen_valid = 1'b1;
                        lat_got = cyc - acc_q[0] - 1;
                        n_tests++;
                        if (lat_got != int'(e[EW-1 -: 8])) begin
                            n_fail++;
                            $display("FAIL latency: got %0d required %0d", lat_got, e[EW-1 -: 8]);
                        end
                    end
                    n_tests++;
                    if ({div_by_zero, quotient, remainder} !== e[RW-1:0]) begin
                        n_fail++;
                        $display("FAIL result: got dbz=%0b q=%0h r=%0h required dbz=%0b q=%0h r=%0h",
                                 div_by_zero, quotient, remainder,
                                 e[RW-1], e[AW+BW-1:BW], e[BW-1:0]);
                    end
                    n_tests++;
                    if (in_ready !== 1'b0) begin
                        n_fail++;
                        $display("FAIL ready_in_done: got in_ready=%0b required 0", in_ready);
                    end
                    if (out_ready === 1'b1) begin
                        void'(exp_q.pop_front());
                        void'(acc_q.pop_front());
                        seen_valid = 1'b0;
                        chk_after  = 1'b1;
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int guard;
        logic [AW-1:0] ra;
        logic [BW-1:0] rb;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        dividend = '0;
        divisor  = '0;

        pulse_reset(3);

        // Basic and boundary divisions, hand-computed.
        or_mode = 0;
        issue(48'd100, 18'd7, 48'd14, 18'd2, 1'b0, 48);
        drain();
        issue(48'hFFFF_FFFF_FFFF, 18'd1, 48'hFFFF_FFFF_FFFF, 18'd0, 1'b0, 48);
        drain();
        issue(48'h13_FFFE, 18'h3FFFF, 48'd5, 18'd3, 1'b0, 48);
        drain();
        issue(48'd1234, 18'd0, 48'hFFFF_FFFF_FFFF, 18'd1234, 1'b1, 0);
        drain();
        issue(48'd5, 18'd9, 48'd0, 18'd5, 1'b0, 48);
        drain();
        issue(48'd0, 18'd77, 48'd0, 18'd0, 1'b0, 48);
        drain();

        // Backpressure: result held for 10 cycles while new requests are offered.
        or_mode = 2;
        issue(48'd1000, 18'd3, 48'd333, 18'd1, 1'b0, 48);
        guard = 0;
        while (out_valid !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("bp_reached_done", out_valid, 1);
        check("bp_state_done", state_dbg, 2);
        repeat (10) begin
            @(negedge clk);
            in_valid = 1'b1;
            dividend = 48'd77;
            divisor  = 18'd5;
        end
        @(negedge clk);
        in_valid = 1'b0;
        or_mode  = 0;
        drain();

        // Reset 20 steps into a calculation, then a clean division.
        issue(48'd9999, 18'd7, 48'd1428, 18'd3, 1'b0, 48);
        repeat (20) @(negedge clk);
        check("mid_state_calc", state_dbg, 1);
        pulse_reset(1);
        issue(48'd9, 18'd3, 48'd3, 18'd0, 1'b0, 48);
        drain();

        // Random operands with random output stalls.
        or_mode = 1;
        for (int i = 0; i < 200; i++) begin
            ra = {16'($urandom()), 32'($urandom())};
            case ($urandom_range(0, 15))
                0:       rb = '0;
                1:       rb = 18'd1;
                2, 3, 4: rb = 18'($urandom_range(1, 15));
                5:       begin rb = 18'($urandom_range(1, 1000)); ra = 48'($urandom_range(0, 999)); end
                default: rb = 18'($urandom());
            endcase
            issue_model(ra, rb);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
